// File: rtl/mem_responder_if.sv
// Request/response bus between the MD/VMA initiator and the memory responder.
interface mem_responder_if #(
  parameter int ADDR_W = 22
);
  logic              memrq;
  logic              wrcyc;
  logic [ADDR_W-1:0] vma;
  logic [31:0]       md;
  logic [31:0]       mds;
  logic              mempar;
  logic              loadmd;
  logic              memack;
  logic              nxm;
  logic              busy;

  modport master (
    output memrq, wrcyc, vma, md,
    input  mds, mempar, loadmd, memack, nxm, busy
  );

  modport slave (
    input  memrq, wrcyc, vma, md,
    output mds, mempar, loadmd, memack, nxm, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Main-memory responder: latches one request, strobes a single-port
// synchronous RAM, returns read data with odd parity and acknowledges.
// Out-of-range addresses are answered as non-existent memory with
// normal latency and no RAM strobe.
module mem_responder #(
  parameter int ADDR_W      = 22,
  parameter int MEM_WORDS   = 65536,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_responder_if.slave    bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata
);

  localparam int                CNT_W     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic              nxm_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       mds_q;
  logic              mempar_q;
  logic              first_access;
  logic [31:0]       rd_value;

  // The counter still holds its load value only in the first ACCESS cycle.
  assign first_access = (cnt_q == CNT_INIT);
  assign rd_value     = nxm_q ? 32'd0 : ram_rdata;
  assign ram_addr     = addr_q;
  assign ram_wdata    = wdata_q;
  assign bus.mds      = mds_q;
  assign bus.mempar   = mempar_q;

  // State register.
  // NOTE: reset is synchronous here, so it only appears inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle strobes decoded from registered state.
  always_comb begin
    // NOTE: defaults first keep every output assigned on all paths (no latches).
    state_d    = state_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    bus.memack = 1'b0;
    bus.loadmd = 1'b0;
    bus.nxm    = 1'b0;
    bus.busy   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.memrq) state_d = ACCESS;
      end
      ACCESS: begin
        if (first_access) begin
          ram_we = wr_q & ~nxm_q;
          ram_re = ~wr_q & ~nxm_q;
        end
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        bus.memack = 1'b1;
        bus.loadmd = ~wr_q;
        bus.nxm    = nxm_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches, wait counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      nxm_q    <= 1'b0;
      cnt_q    <= '0;
      mds_q    <= '0;
      mempar_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.memrq) begin
            addr_q  <= bus.vma;
            wdata_q <= bus.md;
            wr_q    <= bus.wrcyc;
            nxm_q   <= ({1'b0, bus.vma} >= MEM_LIMIT);
            cnt_q   <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // Writes leave the last read data and its parity untouched.
            if (!wr_q) begin
              mds_q    <= rd_value;
              mempar_q <= ~^rd_value;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a driver issues requests
// and queues the expected RAM strobes and responses; a monitor compares
// them whenever the DUT strobes the RAM or acknowledges.
module tb_mem_responder #(
  parameter int WAIT_CYCLES = 1
);
  localparam int ADDR_W    = 22;
  localparam int MEM_WORDS = 65536;
  localparam int IDX_W     = $clog2(MEM_WORDS);

  typedef struct {
    int                cyc;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic        loadmd;
    logic        nxm;
    logic [31:0] mds;
    logic        mempar;
  } resp_t;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  strobe_t     sq[$];
  resp_t       rq[$];
  strobe_t     mon_s;
  resp_t       mon_r;
  logic [31:0] model_mem [int];
  logic [31:0] last_mds;

  bit [31:0] ram_store   [MEM_WORDS];
  bit        ram_written [MEM_WORDS];

  mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  mem_responder #(
    .ADDR_W     (ADDR_W),
    .MEM_WORDS  (MEM_WORDS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Background content of never-written words, shared by RAM and model.
  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic odd_par(input logic [31:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return init_word(int'(a));
  endfunction

  // Synchronous RAM: data appears the cycle after ram_re and then holds.
  always @(posedge clk) begin
    if (ram_we) begin
      ram_store[ram_addr[IDX_W-1:0]]   <= ram_wdata;
      ram_written[ram_addr[IDX_W-1:0]] <= 1'b1;
    end
    if (ram_re) begin
      ram_rdata <= ram_written[ram_addr[IDX_W-1:0]] ? ram_store[ram_addr[IDX_W-1:0]]
                                                   : init_word(int'(ram_addr[IDX_W-1:0]));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe and every acknowledge consumes one expectation.
  always @(negedge clk) begin
    if (ram_we === 1'b1 || ram_re === 1'b1) begin
      if (sq.size() == 0) begin
        check("unexpected_strobe", 64'({ram_we, ram_re}), 64'(0));
      end else begin
        mon_s = sq.pop_front();
        check("strobe_cycle", 64'(cyc), 64'(mon_s.cyc));
        check("strobe_kind", 64'({ram_we, ram_re}), 64'({mon_s.we, ~mon_s.we}));
        check("ram_addr", 64'(ram_addr), 64'(mon_s.addr));
        if (mon_s.we) check("ram_wdata", 64'(ram_wdata), 64'(mon_s.wdata));
      end
    end
    if (bus.memack === 1'b1) begin
      if (rq.size() == 0) begin
        check("unexpected_memack", 64'(1), 64'(0));
      end else begin
        mon_r = rq.pop_front();
        check("memack_cycle", 64'(cyc), 64'(mon_r.cyc));
        check("loadmd", 64'(bus.loadmd), 64'(mon_r.loadmd));
        check("nxm", 64'(bus.nxm), 64'(mon_r.nxm));
        check("mds", 64'(bus.mds), 64'(mon_r.mds));
        check("mempar", 64'(bus.mempar), 64'(mon_r.mempar));
        check("busy_in_resp", 64'(bus.busy), 64'(1));
      end
    end else if (bus.loadmd === 1'b1 || bus.nxm === 1'b1) begin
      check("stray_loadmd_nxm", 64'({bus.loadmd, bus.nxm}), 64'(0));
    end
  end

  // Queue what the memory system must do for a request accepted at edge k.
  task automatic expect_access(input int k, input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [31:0] d, input bit with_resp);
    strobe_t s;
    resp_t   r;
    logic    is_nxm;
    is_nxm = (int'(a) >= MEM_WORDS);
    if (!is_nxm) begin
      s.cyc = k; s.we = wr; s.addr = a; s.wdata = d;
      sq.push_back(s);
    end
    if (wr && !is_nxm) model_mem[int'(a)] = d;
    if (!wr) last_mds = is_nxm ? 32'd0 : model_read(a);
    if (with_resp) begin
      r.cyc = k + WAIT_CYCLES + 1; r.loadmd = ~wr; r.nxm = is_nxm;
      r.mds = last_mds; r.mempar = odd_par(last_mds);
      rq.push_back(r);
    end
  endtask

  // Called on an IDLE negedge; returns on the next IDLE negedge.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input bit keep);
    int k;
    bus.memrq = 1'b1; bus.wrcyc = wr; bus.vma = a; bus.md = d;
    k = cyc + 1;
    expect_access(k, wr, a, d, 1'b1);
    @(negedge clk);
    if (!keep) bus.memrq = 1'b0;
    bus.vma   = ADDR_W'($urandom);
    bus.md    = $urandom;
    bus.wrcyc = 1'($urandom_range(0, 1));
    while (cyc < k + WAIT_CYCLES + 2) @(negedge clk);
  endtask

  task automatic gap();
    bus.memrq = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    bit                keep;
    int                k;

    last_mds  = 32'd0;
    reset     = 1'b1;
    bus.memrq = 1'b0; bus.wrcyc = 1'b0; bus.vma = '0; bus.md = '0;
    repeat (3) @(negedge clk);
    check("reset_mds", 64'(bus.mds), 64'(0));
    check("reset_mempar", 64'(bus.mempar), 64'(1));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_pulses", 64'({bus.memack, bus.loadmd, bus.nxm, ram_we, ram_re}), 64'(0));
    reset = 1'b0;

    // Directed: write then read back, boundary addresses, NXM write.
    issue(1'b1, ADDR_W'('h10), 32'h12345678, 1'b0);
    issue(1'b0, ADDR_W'('h10), 32'h0, 1'b0);
    issue(1'b0, ADDR_W'(MEM_WORDS), 32'h0, 1'b0);
    issue(1'b0, ADDR_W'(MEM_WORDS - 1), 32'h0, 1'b0);
    issue(1'b1, ADDR_W'(MEM_WORDS), 32'hDEADBEEF, 1'b0);
    issue(1'b0, ADDR_W'({ADDR_W{1'b1}}), 32'h0, 1'b0);

    // memrq held high across three requests; junk on vma during ACCESS.
    issue(1'b1, ADDR_W'('h20), 32'hAAAA5555, 1'b1);
    issue(1'b0, ADDR_W'('h20), 32'h0, 1'b1);
    issue(1'b0, ADDR_W'('h10), 32'h0, 1'b0);

    // Reset during the first ACCESS cycle of a read aborts it silently.
    bus.memrq = 1'b1; bus.wrcyc = 1'b0; bus.vma = ADDR_W'('h10);
    k = cyc + 1;
    expect_access(k, 1'b0, ADDR_W'('h10), 32'h0, 1'b0);
    @(negedge clk);
    bus.memrq = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_pulses", 64'({bus.memack, bus.loadmd}), 64'(0));
    check("abort_mds", 64'(bus.mds), 64'(0));
    check("abort_mempar", 64'(bus.mempar), 64'(1));
    reset    = 1'b0;
    last_mds = 32'd0;
    issue(1'b0, ADDR_W'('h20), 32'h0, 1'b0);

    // Randomized traffic: hot low addresses, boundary, full range.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       a = ADDR_W'($urandom_range(0, 15));
        1:       a = ADDR_W'(MEM_WORDS - 2 + int'($urandom_range(0, 3)));
        2:       a = ADDR_W'($urandom);
        default: a = ADDR_W'($urandom_range(0, MEM_WORDS - 1));
      endcase
      keep = (i != 59) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom_range(0, 1)), a, $urandom, keep);
      if (!keep) gap();
    end
    bus.memrq = 1'b0;

    repeat (WAIT_CYCLES + 6) @(negedge clk);
    check("resp_queue_drained", 64'(rq.size()), 64'(0));
    check("strobe_queue_drained", 64'(sq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
